datamover_sts_tracker: RTL and testbench

- Sits on the AXI datamover status path, between the datamover's status output and the status input of the per-stream command master.
- Passes every 8-bit status beat through a one-entry register slice.
- Decodes each beat (tag, INTERR, DECERR, SLVERR, OKAY) and keeps per-stream completion and error counters.
- Raises coalesced per-stream interrupts, controlled through the same set/get register bus as the command master.

---
 rtl/datamover_sts_tracker_pkg.sv | 35 +++
 rtl/datamover_sts_tracker_counters.sv | 100 ++++++++++
 rtl/datamover_sts_tracker.sv | 175 +++++++++++++++++
 tb/tb_datamover_sts_tracker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/datamover_sts_tracker_pkg.sv
// Shared definitions for the datamover status tracker: status bit layout,
// register word offsets, command bits and fixed read values.
package datamover_sts_tracker_pkg;

  localparam int STS_OKAY    = 7;
  localparam int STS_SLVERR  = 6;
  localparam int STS_DECERR  = 5;
  localparam int STS_INTERR  = 4;
  localparam int STS_TAG_MSB = 3;
  localparam int STS_TAG_LSB = 0;
  localparam int STS_TAG_W   = STS_TAG_MSB - STS_TAG_LSB + 1;

  typedef enum logic [2:0] {
    REG_SIG     = 3'd0,
    REG_DONE    = 3'd1,
    REG_ERR     = 3'd2,
    REG_LAST    = 3'd3,
    REG_THRESH  = 3'd4,
    REG_TIMEOUT = 3'd5,
    REG_PENDING = 3'd6,
    REG_CMD     = 3'd7
  } reg_off_e;

  localparam int CMD_CLR_CNT    = 0;
  localparam int CMD_CLR_STICKY = 1;
  localparam int CMD_ACK        = 2;

  localparam logic [15:0] SIG_VALUE      = 16'hac51;
  localparam logic [31:0] UNMAPPED_VALUE = 32'h12345678;

  function automatic logic sts_is_ok(input logic [7:0] sts);
    return sts[STS_OKAY] && !sts[STS_SLVERR] && !sts[STS_DECERR] && !sts[STS_INTERR];
  endfunction

endpackage

// File: rtl/datamover_sts_tracker_counters.sv
// Per-stream state: completion/error counters, sticky error, last status,
// interrupt threshold/timeout and the coalescing timer driving one irq line.
module sts_stream_counters
  import datamover_sts_tracker_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_beat,
  input  logic [7:0]       i_sts,
  input  logic             i_clr_cnt,
  input  logic             i_clr_sticky,
  input  logic             i_ack,
  input  logic             i_thresh_we,
  input  logic             i_timeout_we,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [CNT_W-1:0] o_done_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_err_sticky,
  output logic [7:0]       o_last_sts,
  output logic [CNT_W-1:0] o_threshold,
  output logic [CNT_W-1:0] o_timeout,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_irq
);

  logic [CNT_W-1:0] r_done_cnt, r_err_cnt, r_threshold, r_timeout, r_pending, r_timer;
  logic             r_err_sticky, r_irq;
  logic [7:0]       r_last_sts;

  logic             w_ok, w_err_beat, w_timeout_hit;
  logic [CNT_W-1:0] w_done_next, w_err_next, w_pend_next, w_timer_next;
  logic [CNT_W-1:0] w_thresh_eff, w_thresh_min;
  logic             w_sticky_next, w_irq_next;

  // Clears and acks act first so a beat in the same cycle lands on the cleared value.
  always_comb begin
    w_ok       = sts_is_ok(i_sts);
    w_err_beat = i_beat && !w_ok;

    w_done_next = i_clr_cnt ? '0 : r_done_cnt;
    if (i_beat) w_done_next = w_done_next + CNT_W'(1);

    w_err_next = i_clr_cnt ? '0 : r_err_cnt;
    if (w_err_beat && (w_err_next != '1)) w_err_next = w_err_next + CNT_W'(1);

    w_sticky_next = (i_clr_sticky ? 1'b0 : r_err_sticky) || w_err_beat;

    w_pend_next = i_ack ? '0 : r_pending;
    if (i_beat && (w_pend_next != '1)) w_pend_next = w_pend_next + CNT_W'(1);

    w_timer_next = r_timer;
    if (i_ack || (r_pending == '0)) w_timer_next = '0;
    else if (!r_irq && (r_timer != '1)) w_timer_next = r_timer + CNT_W'(1);

    w_thresh_eff = i_thresh_we ? i_wdata : r_threshold;
    w_thresh_min = (w_thresh_eff == '0) ? CNT_W'(1) : w_thresh_eff;

    w_timeout_hit = (r_timeout != '0) && (r_timer == r_timeout - CNT_W'(1)) &&
                    (r_pending != '0) && !r_irq && !i_ack;

    w_irq_next = (i_ack ? 1'b0 : r_irq) || (w_pend_next >= w_thresh_min) ||
                 w_timeout_hit || w_err_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_cnt   <= '0;
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
      r_last_sts   <= '0;
      r_threshold  <= CNT_W'(1);
      r_timeout    <= '0;
      r_pending    <= '0;
      r_timer      <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_done_cnt   <= w_done_next;
      r_err_cnt    <= w_err_next;
      r_err_sticky <= w_sticky_next;
      if (i_beat) r_last_sts <= i_sts;
      if (i_thresh_we) r_threshold <= i_wdata;
      if (i_timeout_we) r_timeout <= i_wdata;
      r_pending    <= w_pend_next;
      r_timer      <= w_timer_next;
      r_irq        <= w_irq_next;
    end
  end

  assign o_done_cnt   = r_done_cnt;
  assign o_err_cnt    = r_err_cnt;
  assign o_err_sticky = r_err_sticky;
  assign o_last_sts   = r_last_sts;
  assign o_threshold  = r_threshold;
  assign o_timeout    = r_timeout;
  assign o_pending    = r_pending;
  assign o_irq        = r_irq;

endmodule

// File: rtl/datamover_sts_tracker.sv
// Status-path register slice with per-stream decode, counters and coalesced irq.
// Optional macro STS_TAG_CHECK_EN: beats with out-of-range tags are counted, not attributed.
module datamover_sts_tracker
  import datamover_sts_tracker_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_STS_DATA_WIDTH   = 8,
  parameter int C_STREAMS_WIDTH    = 2,
  parameter int C_PAGEWIDTH        = 16,
  parameter int C_CNT_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          S_AXIS_STS_TVALID,
  output logic                          S_AXIS_STS_TREADY,
  input  logic [C_STS_DATA_WIDTH-1:0]   S_AXIS_STS_TDATA,
  output logic                          M_AXIS_STS_TVALID,
  input  logic                          M_AXIS_STS_TREADY,
  output logic [C_STS_DATA_WIDTH-1:0]   M_AXIS_STS_TDATA,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
  input  logic                          set_stb,
  output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
  input  logic                          get_stb,
  output logic [(1<<C_STREAMS_WIDTH)-1:0] irq
);

  localparam int NUM_STREAMS = 1 << C_STREAMS_WIDTH;
  localparam int WORD_W      = C_PAGEWIDTH - 2;
  localparam logic [WORD_W-1:0] LP_BAD_TAG_WORD = WORD_W'(NUM_STREAMS * 8);

  logic                        r_hold_valid;
  logic [C_STS_DATA_WIDTH-1:0] r_hold_data;
  logic                        w_s_ready, w_s_hs;

  assign w_s_ready         = !r_hold_valid || M_AXIS_STS_TREADY;
  assign w_s_hs            = S_AXIS_STS_TVALID && w_s_ready;
  assign S_AXIS_STS_TREADY = w_s_ready;
  assign M_AXIS_STS_TVALID = r_hold_valid;
  assign M_AXIS_STS_TDATA  = r_hold_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_s_ready) begin
      r_hold_valid <= S_AXIS_STS_TVALID;
      if (S_AXIS_STS_TVALID) r_hold_data <= S_AXIS_STS_TDATA;
    end
  end

  logic [STS_TAG_W-1:0]       w_tag;
  logic [C_STREAMS_WIDTH-1:0] w_stream;
  logic                       w_tag_ok;

  assign w_tag    = S_AXIS_STS_TDATA[STS_TAG_MSB:STS_TAG_LSB];
  assign w_stream = w_tag[C_STREAMS_WIDTH-1:0];

  logic [WORD_W-1:0]   w_set_word, w_get_word;
  logic [2:0]          w_set_off;
  logic [WORD_W-4:0]   w_set_page;

  assign w_set_word = set_addr[C_PAGEWIDTH-1:2];
  assign w_get_word = get_addr[C_PAGEWIDTH-1:2];
  assign w_set_off  = w_set_word[2:0];
  assign w_set_page = w_set_word[WORD_W-1:3];

  logic [C_CNT_WIDTH-1:0] w_done_cnt [NUM_STREAMS];
  logic [C_CNT_WIDTH-1:0] w_err_cnt  [NUM_STREAMS];
  logic [C_CNT_WIDTH-1:0] w_thresh   [NUM_STREAMS];
  logic [C_CNT_WIDTH-1:0] w_timeout  [NUM_STREAMS];
  logic [C_CNT_WIDTH-1:0] w_pending  [NUM_STREAMS];
  logic [7:0]             w_last_sts [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] w_err_sticky;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
      logic w_sel;
      logic w_cmd_we;
      assign w_sel    = set_stb && (w_set_page == (WORD_W-3)'(gi));
      assign w_cmd_we = w_sel && (w_set_off == REG_CMD);

      sts_stream_counters #(.CNT_W(C_CNT_WIDTH)) u_counters (
        .clk          (clk),
        .rst          (rst),
        .i_beat       (w_s_hs && w_tag_ok && (w_stream == C_STREAMS_WIDTH'(gi))),
        .i_sts        (S_AXIS_STS_TDATA[7:0]),
        .i_clr_cnt    (w_cmd_we && set_data[CMD_CLR_CNT]),
        .i_clr_sticky (w_cmd_we && set_data[CMD_CLR_STICKY]),
        .i_ack        (w_cmd_we && set_data[CMD_ACK]),
        .i_thresh_we  (w_sel && (w_set_off == REG_THRESH)),
        .i_timeout_we (w_sel && (w_set_off == REG_TIMEOUT)),
        .i_wdata      (set_data[C_CNT_WIDTH-1:0]),
        .o_done_cnt   (w_done_cnt[gi]),
        .o_err_cnt    (w_err_cnt[gi]),
        .o_err_sticky (w_err_sticky[gi]),
        .o_last_sts   (w_last_sts[gi]),
        .o_threshold  (w_thresh[gi]),
        .o_timeout    (w_timeout[gi]),
        .o_pending    (w_pending[gi]),
        .o_irq        (irq[gi])
      );
    end
  endgenerate

`ifdef STS_TAG_CHECK_EN
  logic [C_CNT_WIDTH-1:0] r_bad_tag_cnt, w_bad_tag_next;

  assign w_tag_ok = (w_tag >> C_STREAMS_WIDTH) == '0;

  always_comb begin
    w_bad_tag_next = (set_stb && (w_set_word == LP_BAD_TAG_WORD)) ? '0 : r_bad_tag_cnt;
    if (w_s_hs && !w_tag_ok && (w_bad_tag_next != '1))
      w_bad_tag_next = w_bad_tag_next + C_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_bad_tag_cnt <= '0;
    else     r_bad_tag_cnt <= w_bad_tag_next;
  end

  logic w_unused;
  assign w_unused = ^{set_addr[C_S_AXI_ADDR_WIDTH-1:C_PAGEWIDTH], set_addr[1:0],
                      get_addr[C_S_AXI_ADDR_WIDTH-1:C_PAGEWIDTH], get_addr[1:0],
                      set_data[C_S_AXI_DATA_WIDTH-1:C_CNT_WIDTH]};
`else
  assign w_tag_ok = 1'b1;

  logic w_unused;
  assign w_unused = ^{set_addr[C_S_AXI_ADDR_WIDTH-1:C_PAGEWIDTH], set_addr[1:0],
                      get_addr[C_S_AXI_ADDR_WIDTH-1:C_PAGEWIDTH], get_addr[1:0],
                      set_data[C_S_AXI_DATA_WIDTH-1:C_CNT_WIDTH],
                      w_tag[STS_TAG_W-1:C_STREAMS_WIDTH]};
`endif

  logic [C_STREAMS_WIDTH-1:0]    w_get_stream;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data, r_get_data;

  assign w_get_stream = w_get_word[C_STREAMS_WIDTH+2:3];

  // Write-only command words and anything outside the stream pages read as the filler value.
  always_comb begin
    w_rd_data = C_S_AXI_DATA_WIDTH'(UNMAPPED_VALUE);
    if (w_get_word < LP_BAD_TAG_WORD) begin
      case (reg_off_e'(w_get_word[2:0]))
        REG_SIG:     w_rd_data = C_S_AXI_DATA_WIDTH'({SIG_VALUE, 16'(w_get_stream)});
        REG_DONE:    w_rd_data = C_S_AXI_DATA_WIDTH'(w_done_cnt[w_get_stream]);
        REG_ERR:     w_rd_data = C_S_AXI_DATA_WIDTH'(w_err_cnt[w_get_stream]);
        REG_LAST: begin
          w_rd_data = '0;
          w_rd_data[C_S_AXI_DATA_WIDTH-1] = w_err_sticky[w_get_stream];
          w_rd_data[7:0] = w_last_sts[w_get_stream];
        end
        REG_THRESH:  w_rd_data = C_S_AXI_DATA_WIDTH'(w_thresh[w_get_stream]);
        REG_TIMEOUT: w_rd_data = C_S_AXI_DATA_WIDTH'(w_timeout[w_get_stream]);
        REG_PENDING: w_rd_data = C_S_AXI_DATA_WIDTH'(w_pending[w_get_stream]);
        default:     w_rd_data = C_S_AXI_DATA_WIDTH'(UNMAPPED_VALUE);
      endcase
    end
`ifdef STS_TAG_CHECK_EN
    if (w_get_word == LP_BAD_TAG_WORD) w_rd_data = C_S_AXI_DATA_WIDTH'(r_bad_tag_cnt);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)          r_get_data <= '0;
    else if (get_stb) r_get_data <= w_rd_data;
  end

  assign get_data = r_get_data;

endmodule

// File: tb/tb_datamover_sts_tracker.sv
// Directed self-checking bench for datamover_sts_tracker (default parameters).
module tb_datamover_sts_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tready, m_tvalid, m_tready;
  logic [7:0]  s_tdata, m_tdata;
  logic [31:0] set_data, set_addr, get_data, get_addr;
  logic        set_stb, get_stb;
  logic [3:0]  irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  datamover_sts_tracker dut (
    .clk               (clk),
    .rst               (rst),
    .S_AXIS_STS_TVALID (s_tvalid),
    .S_AXIS_STS_TREADY (s_tready),
    .S_AXIS_STS_TDATA  (s_tdata),
    .M_AXIS_STS_TVALID (m_tvalid),
    .M_AXIS_STS_TREADY (m_tready),
    .M_AXIS_STS_TDATA  (m_tdata),
    .set_data          (set_data),
    .set_addr          (set_addr),
    .set_stb           (set_stb),
    .get_data          (get_data),
    .get_addr          (get_addr),
    .get_stb           (get_stb),
    .irq               (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int word, input logic [31:0] d);
    set_addr = 32'(word) << 2;
    set_data = d;
    set_stb  = 1'b1;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int word, input logic [31:0] exp);
    get_addr = 32'(word) << 2;
    get_stb  = 1'b1;
    tick();
    get_stb  = 1'b0;
    chk(tag, get_data, exp);
  endtask

  task automatic beat(input logic [7:0] d);
    s_tvalid = 1'b1;
    s_tdata  = d;
    tick();
    s_tvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    set_data = '0; set_addr = '0; set_stb = 1'b0; get_addr = '0; get_stb = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_get_data", get_data, 0);
    chk("rst_irq", irq, 0);
    chk("rst_s_tready", s_tready, 1);

    // Four back-to-back OKAY beats, one per stream.
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'h80 + 8'(i);
      #1;
      chk("thru_s_tready", s_tready, 1);
      tick();
      chk("thru_m_tvalid", m_tvalid, 1);
      chk("thru_m_tdata", m_tdata, 32'h80 + 32'(i));
    end
    s_tvalid = 1'b0;
    tick();
    chk("thru_drain", m_tvalid, 0);
    chk("thr1_irq_all", irq, 4'hf);
    for (int m = 0; m < 4; m++) rd_chk("done_each", m * 8 + 1, 1);
    rd_chk("sig1", 8, 32'hac510001);
    rd_chk("sig3", 24, 32'hac510003);
    rd_chk("cmd_unmapped", 7, 32'h12345678);
    rd_chk("thresh_rst", 4, 1);
    for (int m = 0; m < 4; m++) wr(m * 8 + 7, 32'h4);
    chk("ack_all", irq, 0);

    // Backpressure: first beat held, second waits.
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'h81;
    #1;
    chk("stall_first_ready", s_tready, 1);
    tick();
    s_tdata = 8'h82;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_s_tready", s_tready, 0);
      chk("stall_m_tvalid", m_tvalid, 1);
      chk("stall_m_tdata", m_tdata, 32'h81);
      tick();
    end
    m_tready = 1'b1;
    #1;
    chk("release_s_tready", s_tready, 1);
    tick();
    chk("release_m_tvalid", m_tvalid, 1);
    chk("release_m_tdata", m_tdata, 32'h82);
    s_tvalid = 1'b0;
    tick();
    chk("release_drain", m_tvalid, 0);
    rd_chk("stall_done1", 9, 2);
    rd_chk("stall_done2", 17, 2);
    wr(15, 32'h4);
    wr(23, 32'h4);

    // Threshold coalescing on stream 1.
    wr(12, 3);
    wr(13, 0);
    rd_chk("thresh_rb", 12, 3);
    beat(8'h81);
    chk("thr_irq_b1", irq[1], 0);
    beat(8'h81);
    chk("thr_irq_b2", irq[1], 0);
    beat(8'h81);
    chk("thr_irq_b3", irq[1], 1);
    rd_chk("thr_pending", 14, 3);
    wr(15, 32'h4);
    chk("thr_ack_irq", irq[1], 0);
    rd_chk("thr_ack_pending", 14, 0);

    // Timeout coalescing on stream 2.
    wr(20, 8);
    wr(21, 20);
    beat(8'h82);
    for (int k = 1; k < 20; k++) begin
      tick();
      chk("to_irq_early", irq[2], 0);
    end
    tick();
    chk("to_irq_fire", irq[2], 1);

    // Error beat on stream 3.
    wr(28, 8);
    chk("err_irq_pre", irq[3], 0);
    beat(8'h43);
    chk("err_irq", irq[3], 1);
    chk("err_passthru", m_tdata, 32'h43);
    rd_chk("err_cnt", 26, 1);
    rd_chk("err_last", 27, 32'h80000043);
    wr(31, 32'h2);
    rd_chk("err_sticky_clr", 27, 32'h00000043);
    rd_chk("err_done", 25, 2);

    // Clear and ack coinciding with a beat on stream 0.
    beat(8'h80);
    set_addr = 32'(7) << 2; set_data = 32'h5; set_stb = 1'b1;
    beat(8'h80);
    set_stb = 1'b0;
    chk("sim_irq", irq[0], 1);
    rd_chk("sim_done", 1, 1);
    rd_chk("sim_pending", 6, 1);

    // Out-of-range tag handling.
    wr(15, 32'h1);
    beat(8'h85);
    chk("badtag_passthru", m_tdata, 32'h85);
`ifdef STS_TAG_CHECK_EN
    rd_chk("badtag_done1", 9, 0);
    rd_chk("badtag_cnt", 32, 1);
    wr(32, 0);
    rd_chk("badtag_clr", 32, 0);
`else
    rd_chk("badtag_done1", 9, 1);
    rd_chk("badtag_unmapped", 32, 32'h12345678);
`endif

    // Reset while a beat is held.
    m_tready = 1'b0;
    beat(8'h81);
    chk("rst_mid_held", m_tvalid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_drop", m_tvalid, 0);
    chk("rst_mid_irq", irq, 0);
    m_tready = 1'b1;
    rd_chk("rst_mid_thresh", 20, 1);
    rd_chk("rst_mid_done", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
